// File: rtl/lm_sm_sequencer.sv
// Memory-stage sequencer for LM/SM multi-register transfers in the 16-bit pipeline.
// Walks the register mask lowest-first, one transfer per cycle, and stalls the pipeline until the final transfer.
module lm_sm_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [NREG-1:0]   reg_mask,
  input  logic [DATA_W-1:0] base_addr,
  input  logic              pipe_mem_read,
  input  logic              pipe_mem_write,
  input  logic [DATA_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [IDX_W-1:0]  rf_rd_addr,
  output logic              rf_wr_en,
  output logic [IDX_W-1:0]  rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              stall,
  output logic              done,
  output logic              busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nx;
  logic [NREG-1:0]   mask_r, mask_nx;
  logic [DATA_W-1:0] addr_r, addr_nx;
  logic              store_r, store_nx;

  logic [IDX_W-1:0]  k;
  logic [NREG-1:0]   mask_rest;
  logic              last;
  logic              start_ok;

  // Gating start with rst_n keeps the outputs at pass-through values while reset is held.
  assign start_ok  = start & rst_n;
  assign mask_rest = mask_r & (mask_r - NREG'(1));
  assign last      = (mask_rest == '0);
  assign busy      = (state == RUN);

  // Scanning downward leaves the lowest set bit as the winner.
  always_comb begin
    k = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask_r[i]) k = IDX_W'(i);
    end
  end

  // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx   = state;
    mask_nx    = mask_r;
    addr_nx    = addr_r;
    store_nx   = store_r;
    mem_addr   = pipe_addr;
    mem_read   = pipe_mem_read;
    mem_write  = pipe_mem_write;
    mem_wdata  = rf_rd_data;
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    stall      = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        if (start_ok) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
          if (reg_mask == '0) begin
            done = 1'b1;
          end else begin
            stall    = 1'b1;
            mask_nx  = reg_mask;
            addr_nx  = base_addr;
            store_nx = is_store;
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        mem_addr  = addr_r;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (store_r) begin
          mem_write  = 1'b1;
          rf_rd_addr = k;
        end else begin
          mem_read   = 1'b1;
          rf_wr_en   = 1'b1;
          rf_wr_addr = k;
          rf_wr_data = mem_rdata;
        end
        mask_nx = mask_rest;
        addr_nx = addr_r + DATA_W'(1);
        if (last) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mask_r  <= '0;
      addr_r  <= '0;
      store_r <= 1'b0;
    end else begin
      state   <= state_nx;
      mask_r  <= mask_nx;
      addr_r  <= addr_nx;
      store_r <= store_nx;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: queue-based transfer model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lm_sm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [7:0]  reg_mask;
  logic [15:0] base_addr;
  logic        pipe_mem_read;
  logic        pipe_mem_write;
  logic [15:0] pipe_addr;
  logic [15:0] mem_rdata;
  logic [15:0] rf_rd_data;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic [2:0]  rf_rd_addr;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic        stall;
  logic        done;
  logic        busy;

  lm_sm_sequencer #(.DATA_W(16), .NREG(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .reg_mask(reg_mask), .base_addr(base_addr),
    .pipe_mem_read(pipe_mem_read), .pipe_mem_write(pipe_mem_write), .pipe_addr(pipe_addr),
    .mem_rdata(mem_rdata), .rf_rd_data(rf_rd_data),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .rf_rd_addr(rf_rd_addr), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .stall(stall), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: combinational-read data memory and register file.
  logic [15:0] tb_mem [0:65535];
  logic [15:0] tb_rf  [0:7];
  assign mem_rdata  = tb_mem[mem_addr];
  assign rf_rd_data = tb_rf[rf_rd_addr];

  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr] <= mem_wdata;
    if (rf_wr_en)  tb_rf[rf_wr_addr] <= rf_wr_data;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an instruction in flight is a queue of register indices still to transfer.
  logic       m_busy = 1'b0;
  logic [2:0] m_q [$];
  logic [15:0] m_addr = '0;
  logic       m_store = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_q.delete();
      m_addr = '0;
      m_store = 1'b0;
    end else if (m_busy) begin
      void'(m_q.pop_front());
      m_addr = m_addr + 16'd1;
      if (m_q.size() == 0) m_busy = 1'b0;
    end else if (start && reg_mask != 8'h00) begin
      m_q.delete();
      for (int i = 0; i < 8; i++) if (reg_mask[i]) m_q.push_back(3'(i));
      m_addr  = base_addr;
      m_store = is_store;
      m_busy  = 1'b1;
    end
  end

  logic [15:0] e_addr, e_wdata, e_wd;
  logic        e_rd, e_wr, e_wen, e_stall, e_done, e_busy;
  logic [2:0]  e_rda, e_wa;

  always @(negedge clk) begin
    e_addr = pipe_addr; e_rd = pipe_mem_read; e_wr = pipe_mem_write;
    e_rda = '0; e_wen = 1'b0; e_wa = '0; e_wd = '0;
    e_stall = 1'b0; e_done = 1'b0; e_busy = m_busy;
    if (m_busy) begin
      e_addr = m_addr;
      e_rd   = !m_store;
      e_wr   = m_store;
      if (m_store) begin
        e_rda = m_q[0];
      end else begin
        e_wen = 1'b1;
        e_wa  = m_q[0];
        e_wd  = tb_mem[m_addr];
      end
      e_done  = (m_q.size() == 1);
      e_stall = !e_done;
    end else if (start && rst_n) begin
      e_rd = 1'b0;
      e_wr = 1'b0;
      if (reg_mask == 8'h00) e_done = 1'b1;
      else e_stall = 1'b1;
    end
    e_wdata = tb_rf[e_rda];
    check("cycle_outputs",
          {mem_addr, mem_read, mem_write, mem_wdata, rf_rd_addr, rf_wr_en, rf_wr_addr,
           rf_wr_data, stall, done, busy},
          {e_addr, e_rd, e_wr, e_wdata, e_rda, e_wen, e_wa, e_wd, e_stall, e_done, e_busy});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; is_store = 1'b0; reg_mask = '0; base_addr = '0;
    pipe_mem_read = 1'b0; pipe_mem_write = 1'b0; pipe_addr = '0;
  endtask

  logic [2:0]  stall_pat;
  logic        lm_done;
  int          wr_cnt, done_at;
  logic [15:0] seen_addr [0:7];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int a = 0; a < 65536; a++) tb_mem[a] <= 16'($urandom);
    for (int r = 0; r < 8; r++) tb_rf[r] <= 16'h0000;

    // Reset: start is ignored and pass-through values appear.
    #2;
    start = 1'b1; reg_mask = 8'h03; pipe_addr = 16'h1234; pipe_mem_write = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_passthru_addr", mem_addr, 16'h1234);
    check("rst_passthru_wr", mem_write, 1'b1);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    // Normal load passes straight through.
    pipe_mem_read = 1'b1; pipe_addr = 16'h0010;
    #2;
    check("norm_addr", mem_addr, 16'h0010);
    check("norm_read", mem_read, 1'b1);
    check("norm_stall", stall, 1'b0);
    check("norm_rf_wr_en", rf_wr_en, 1'b0);
    tick();
    idle_inputs();

    // LM mask 0000_0101 from 0x0040.
    tb_mem[16'h0040] <= 16'hAAAA;
    tb_mem[16'h0041] <= 16'hBBBB;
    start = 1'b1; is_store = 1'b0; reg_mask = 8'h05; base_addr = 16'h0040;
    #2; stall_pat[2] = stall;
    tick(); idle_inputs();
    #2; stall_pat[1] = stall;
    tick();
    #2; stall_pat[0] = stall; lm_done = done;
    tick();
    check("lm_stall_pattern", stall_pat, 3'b110);
    check("lm_done_last", lm_done, 1'b1);
    check("lm_r0", tb_rf[0], 16'hAAAA);
    check("lm_r2", tb_rf[2], 16'hBBBB);

    // SM mask 1000_0001 to 0x0100; pipe_mem_write held high must not leak through.
    tb_rf[0] <= 16'h1234;
    tb_rf[7] <= 16'h5678;
    start = 1'b1; is_store = 1'b1; reg_mask = 8'h81; base_addr = 16'h0100; pipe_mem_write = 1'b1;
    wr_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      #2; wr_cnt += int'(mem_write);
      tick();
      start = 1'b0;
    end
    idle_inputs();
    #2; wr_cnt += int'(mem_write);
    tick();
    check("sm_write_cycles", wr_cnt, 2);
    check("sm_mem100", tb_mem[16'h0100], 16'h1234);
    check("sm_mem101", tb_mem[16'h0101], 16'h5678);

    // Empty mask completes in the accept cycle with no access.
    start = 1'b1; reg_mask = 8'h00; pipe_mem_read = 1'b1; pipe_mem_write = 1'b1;
    #2;
    check("zero_done", done, 1'b1);
    check("zero_stall", stall, 1'b0);
    check("zero_read", mem_read, 1'b0);
    check("zero_write", mem_write, 1'b0);
    tick();
    idle_inputs();
    #2;
    check("zero_stays_idle", busy, 1'b0);
    tick();

    // LM all registers from 0xFFFE: address wraps through 0x0000.
    for (int i = 0; i < 8; i++) tb_mem[16'(16'hFFFE + i)] <= 16'(16'hFFFE + i) ^ 16'h5A5A;
    start = 1'b1; is_store = 1'b0; reg_mask = 8'hFF; base_addr = 16'hFFFE;
    #2;
    check("ff_accept_stall", stall, 1'b1);
    tick();
    idle_inputs();
    wr_cnt = 0; done_at = -1;
    for (int i = 0; i < 8; i++) begin
      #2;
      seen_addr[i] = mem_addr;
      wr_cnt += int'(rf_wr_en);
      if (done) done_at = i;
      tick();
    end
    for (int i = 0; i < 8; i++) check("ff_addr", seen_addr[i], 16'(16'hFFFE + i));
    check("ff_writes", wr_cnt, 8);
    check("ff_done_on_8th", done_at, 7);
    for (int i = 0; i < 8; i++) check("ff_rf", tb_rf[i], 16'(16'hFFFE + i) ^ 16'h5A5A);

    // Reset after 2 of 4 transfers aborts the rest.
    for (int i = 0; i < 4; i++) begin
      tb_rf[i] <= 16'hDEAD;
      tb_mem[16'h0200 + 16'(i)] <= 16'h1111 * 16'(i + 1);
    end
    start = 1'b1; is_store = 1'b0; reg_mask = 8'h0F; base_addr = 16'h0200;
    tick();
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_read", mem_read, 1'b0);
    check("abort_rf_wr_en", rf_wr_en, 1'b0);
    check("abort_stall", stall, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    check("abort_idle_after", busy, 1'b0);
    tick();
    check("abort_r0", tb_rf[0], 16'h1111);
    check("abort_r1", tb_rf[1], 16'h2222);
    check("abort_r2", tb_rf[2], 16'hDEAD);
    check("abort_r3", tb_rf[3], 16'hDEAD);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 600; c++) begin
      pipe_mem_read  = 1'($urandom);
      pipe_mem_write = 1'($urandom);
      pipe_addr      = 16'($urandom);
      is_store       = 1'($urandom);
      base_addr      = 16'($urandom);
      reg_mask       = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      start          = (!m_busy && $urandom_range(0, 2) == 0);
      if (!start) begin
        for (int r = 0; r < 8; r++) if ($urandom_range(0, 7) == 0) tb_rf[r] <= 16'($urandom);
      end
      tick();
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Controls the memory stage for multi-register load/store instructions (LM/SM) in the 16-bit pipeline.
- On acceptance of an LM/SM, takes over the data-memory address and read/write controls and the register-file port indices.
- Steps through each register selected in an 8-bit mask, one transfer per cycle, and stalls the upstream pipeline until the last transfer.
- For all other instructions it forwards the normal MEM-stage controls unchanged.

Parameters:
- DATA_W, 16, data and address width.
- NREG, 8, register count; sets the mask width.
- IDX_W, 3, register index width (log2 NREG).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  valid LM/SM in MEM stage this cycle.
- is_store  input  1  1 = SM, 0 = LM; sampled with start.
- reg_mask  input  NREG  bit i set = transfer Ri; sampled with start.
- base_addr  input  DATA_W  start address (ALU output); sampled with start.
- pipe_mem_read  input  1  normal-instruction memory read.
- pipe_mem_write  input  1  normal-instruction memory write.
- pipe_addr  input  DATA_W  normal-instruction memory address.
- mem_rdata  input  DATA_W  data-memory read data (combinational read).
- rf_rd_data  input  DATA_W  register-file read data for rf_rd_addr.
- mem_addr  output  DATA_W  data-memory address.
- mem_read  output  1  data-memory read enable.
- mem_write  output  1  data-memory write enable.
- mem_wdata  output  DATA_W  data-memory write data.
- rf_rd_addr  output  IDX_W  register index read for SM.
- rf_wr_en  output  1  register-file write enable for LM.
- rf_wr_addr  output  IDX_W  register index written for LM.
- rf_wr_data  output  DATA_W  LM write data.
- stall  output  1  hold IF..EX and the MEM pipeline register.
- done  output  1  one-cycle pulse on the final cycle of an LM/SM.
- busy  output  1  state is RUN.

Behaviour:
- States: IDLE, RUN. Registers: state, mask_r (NREG), addr_r (DATA_W), store_r.
- Reset (async, rst_n=0): state=IDLE, mask_r=0, addr_r=0, store_r=0.
  - During reset all outputs are 0, except the pass-through values below.
- Pass-through (IDLE, start=0): mem_addr=pipe_addr, mem_read=pipe_mem_read, mem_write=pipe_mem_write, mem_wdata=rf_rd_data.
  - rf_wr_en=0, stall=0, done=0.
- IDLE, start=1, reg_mask!=0:
  - mem_read=0, mem_write=0, stall=1.
  - Next edge: mask_r=reg_mask, addr_r=base_addr, store_r=is_store, state=RUN.
- IDLE, start=1, reg_mask==0:
  - No memory access; done=1, stall=0; stays IDLE.
- RUN, each cycle: k = lowest set bit index of mask_r (R0 first).
  - mem_addr=addr_r.
  - SM: mem_write=1, rf_rd_addr=k, mem_wdata=rf_rd_data.
  - LM: mem_read=1, rf_wr_en=1, rf_wr_addr=k, rf_wr_data=mem_rdata.
  - Next edge: clear bit k in mask_r; addr_r=addr_r+1, modulo 2^DATA_W (0xFFFF wraps to 0x0000).
- Final transfer (exactly one bit left in mask_r):
  - done=1, stall=0, so the pipeline advances on the same edge.
  - Next state IDLE.
- In all other RUN cycles: stall=1, done=0.
- Latency: N set bits gives N transfer cycles after the accept cycle; the instruction holds MEM for N+1 cycles total.
- start in RUN is ignored; the upstream pipeline is stalled, so start must not assert there.
- pipe_* inputs are ignored in RUN.
- rst_n low mid-RUN: abort immediately, no further transfers. Memory and register-file writes already done are kept.
- Unused outputs (rf_rd_addr, rf_wr_addr) are 0 when not active.

Test Plan:
- LM, reg_mask=8'b0000_0101, base 0x0040, mem[0x40]=0xAAAA, mem[0x41]=0xBBBB:
  - Stall 1 cycle, then R0<=0xAAAA, then R2<=0xBBBB with done=1.
  - stall pattern 1,1,0.
- SM, reg_mask=8'b1000_0001, R0=0x1234, R7=0x5678, base 0x0100:
  - mem[0x100]=0x1234, mem[0x101]=0x5678.
  - mem_write high exactly 2 cycles.
- reg_mask=0x00 with start:
  - done=1 in the same cycle, stall=0, no mem_read/mem_write.
- LM with reg_mask=0xFF, base 0xFFFE:
  - Addresses 0xFFFE, 0xFFFF, 0x0000..0x0005; 8 writes R0..R7.
  - done on the 8th transfer.
- Normal load (start=0, pipe_mem_read=1, pipe_addr=0x0010):
  - mem_addr=0x0010, mem_read=1, stall=0, rf_wr_en=0.
- rst_n low after 2 of 4 transfers:
  - Outputs go to reset values asynchronously; remaining registers untouched.
  - After release, state IDLE and busy=0.
